// File: rtl/vend_kiosk_arbiter_if.sv
// Kiosk-side handshake bundle for vend_kiosk_arbiter: per-kiosk transaction
// requests in, one-hot grant/done and the shared result out.
interface vend_kiosk_arbiter_if #(
    parameter int NUM_KIOSK = 2
);
    logic [NUM_KIOSK-1:0]   req;
    logic [2*NUM_KIOSK-1:0] req_coins;
    logic [2*NUM_KIOSK-1:0] req_sel;
    logic [NUM_KIOSK-1:0]   req_cancel;
    logic [NUM_KIOSK-1:0]   gnt;
    logic [NUM_KIOSK-1:0]   done;
    logic [1:0]             rsp_drink;
    logic [1:0]             rsp_refund;
    logic                   err;

    modport master (
        output req, req_coins, req_sel, req_cancel,
        input  gnt, done, rsp_drink, rsp_refund, err
    );

    modport slave (
        input  req, req_coins, req_sel, req_cancel,
        output gnt, done, rsp_drink, rsp_refund, err
    );
endinterface

// File: rtl/vend_kiosk_arbiter.sv
// Round-robin arbiter sharing one vending core between NUM_KIOSK kiosks; replays
// each latched transaction to the core as strobes and returns the result.
module vend_kiosk_arbiter #(
    parameter int NUM_KIOSK = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    vend_kiosk_arbiter_if.slave  kiosk,
    output logic                 busy,
    output logic                 core_coin_in,
    output logic                 core_cancel,
    output logic [1:0]           core_selection,
    input  logic [1:0]           core_drink_out,
    input  logic [1:0]           core_refund,
    input  logic [1:0]           core_state
);
    localparam int PW = (NUM_KIOSK > 1) ? $clog2(NUM_KIOSK) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, COIN, CHECK, CMD, RESP, REJECT, FLUSH} state_t;

    state_t               state, state_next;
    logic [PW-1:0]        ptr, win, next_ptr;
    logic                 found;
    logic [NUM_KIOSK-1:0] onehot;
    logic [1:0]           win_coins, win_sel;
    logic                 win_cancel;

    logic [NUM_KIOSK-1:0] gnt_r, done_r;
    logic [1:0]           rsp_drink_r, rsp_refund_r;
    logic                 err_r;
    logic [1:0]           coins_r, sel_r, coin_cnt;
    logic                 cancel_r, cmd_cancel, mark;
    logic [TW-1:0]        to_cnt;
    logic                 hit, mismatch, sel_bad;

    assign hit      = (core_drink_out != '0) || (core_refund != '0);
    assign mismatch = (core_state != coins_r);
    assign sel_bad  = (sel_r == '0) || (sel_r > coins_r);

    // First requester at or after the pointer, wrapping.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NUM_KIOSK; i++) begin
            idx = (32'(ptr) + i) % NUM_KIOSK;
            if (!found && kiosk.req[PW'(idx)]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        onehot      = '0;
        onehot[win] = 1'b1;
        win_coins   = kiosk.req_coins[{win, 1'b0} +: 2];
        win_sel     = kiosk.req_sel[{win, 1'b0} +: 2];
        win_cancel  = kiosk.req_cancel[win];
        next_ptr    = (win == PW'(NUM_KIOSK - 1)) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (core_state != '0) state_next = FLUSH;
                else if (found)       state_next = (win_coins == '0) ? REJECT : COIN;
            end
            COIN:    if (coin_cnt == coins_r - 2'd1) state_next = CHECK;
            CHECK:   state_next = CMD;
            CMD:     state_next = RESP;
            RESP:    if (hit || to_cnt == TO_LAST) state_next = IDLE;
            REJECT:  state_next = IDLE;
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state != IDLE);
        core_coin_in   = (state == COIN);
        core_cancel    = (state == FLUSH) || (state == CMD && cmd_cancel);
        core_selection = (state == CMD && !cmd_cancel) ? sel_r : 2'b00;
    end

    // done/rsp/err default low each cycle; gnt clears on the edge ending the
    // done cycle unless IDLE hands out a new grant on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            gnt_r        <= '0;
            done_r       <= '0;
            rsp_drink_r  <= '0;
            rsp_refund_r <= '0;
            err_r        <= 1'b0;
            coins_r      <= '0;
            sel_r        <= '0;
            cancel_r     <= 1'b0;
            cmd_cancel   <= 1'b0;
            mark         <= 1'b0;
            coin_cnt     <= '0;
            to_cnt       <= '0;
        end else begin
            done_r       <= '0;
            rsp_drink_r  <= '0;
            rsp_refund_r <= '0;
            err_r        <= 1'b0;
            if (done_r != '0) gnt_r <= '0;
            case (state)
                IDLE: begin
                    if (core_state == '0 && found) begin
                        gnt_r    <= onehot;
                        ptr      <= next_ptr;
                        coins_r  <= win_coins;
                        sel_r    <= win_sel;
                        cancel_r <= win_cancel;
                        coin_cnt <= '0;
                        to_cnt   <= '0;
                        if (win_coins == '0) begin
                            done_r <= onehot;
                            err_r  <= 1'b1;
                        end
                    end
                end
                COIN: coin_cnt <= coin_cnt + 2'd1;
                CHECK: begin
                    mark       <= mismatch || (!cancel_r && sel_bad);
                    cmd_cancel <= cancel_r || mismatch || sel_bad;
                end
                RESP: begin
                    if (hit) begin
                        done_r       <= gnt_r;
                        rsp_drink_r  <= core_drink_out;
                        rsp_refund_r <= core_refund;
                        err_r        <= mark;
                    end else if (to_cnt == TO_LAST) begin
                        done_r <= gnt_r;
                        err_r  <= 1'b1;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign kiosk.gnt        = gnt_r;
    assign kiosk.done       = done_r;
    assign kiosk.rsp_drink  = rsp_drink_r;
    assign kiosk.rsp_refund = rsp_refund_r;
    assign kiosk.err        = err_r;
endmodule

// File: tb/tb_vend_kiosk_arbiter.sv
// Bench for vend_kiosk_arbiter: behavioural vending core, directed scenarios and
// randomized multi-kiosk rounds checked against a transaction-level model.
module tb_vend_kiosk_arbiter;
    localparam int NK = 2;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       busy, core_coin_in, core_cancel;
    logic [1:0] core_selection, core_drink_out, core_refund, core_state;

    vend_kiosk_arbiter_if #(.NUM_KIOSK(NK)) kif ();

    vend_kiosk_arbiter #(.NUM_KIOSK(NK), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .kiosk          (kif),
        .busy           (busy),
        .core_coin_in   (core_coin_in),
        .core_cancel    (core_cancel),
        .core_selection (core_selection),
        .core_drink_out (core_drink_out),
        .core_refund    (core_refund),
        .core_state     (core_state)
    );

    // Vending core model: prices equal the selection code.
    logic [1:0] cs, cdrink, crefund, cs_load_val;
    bit         silent, cs_load;
    always @(posedge clk) begin
        if (rst) begin
            cs <= '0; cdrink <= '0; crefund <= '0;
        end else begin
            cdrink  <= '0;
            crefund <= '0;
            if (cs_load) cs <= cs_load_val;
            else if (core_coin_in) cs <= cs + 2'd1;
            else if (core_cancel) begin
                if (!silent) crefund <= cs;
                cs <= '0;
            end else if (core_selection != '0 && cs >= core_selection) begin
                if (!silent) begin
                    cdrink  <= core_selection;
                    crefund <= cs - core_selection;
                end
                cs <= '0;
            end
        end
    end
    assign core_state     = cs;
    assign core_drink_out = cdrink;
    assign core_refund    = crefund;

    int vectors = 0;
    int miscompares = 0;

    bit [NK-1:0] reqv;
    logic [1:0]  kc [NK];
    logic [1:0]  ks [NK];
    bit          kx [NK];
    int          ptr_m = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NK; i++) begin
            kif.req[i]            = reqv[i];
            kif.req_coins[2*i+:2] = kc[i];
            kif.req_sel[2*i+:2]   = ks[i];
            kif.req_cancel[i]     = kx[i];
        end
    endtask

    function automatic int pick(input bit [NK-1:0] m);
        for (int i = 0; i < NK; i++) begin
            if (m[(ptr_m + i) % NK]) return (ptr_m + i) % NK;
        end
        return 0;
    endfunction

    task automatic set_kiosk(input int k, input int c, input int s, input bit x);
        kc[k] = 2'(c); ks[k] = 2'(s); kx[k] = x; reqv[k] = 1'b1;
        apply();
    endtask

    // drop_mode: 0 keep req, 1 drop winner, 2 drop all.
    task automatic serve(input int drop_mode, input bit scramble, input bit silent_exp);
        int k, n, c, s, L, ed, er, ee, coins_seen, cmd_seen, sel_seen, canc_seen;
        bit x, fc;
        k = pick(reqv);
        n = 0;
        while (kif.gnt == '0 && n < 50) begin @(negedge clk); n++; end
        check("grant", 32'(kif.gnt), 32'(1 << k));
        c = int'(kc[k]); s = int'(ks[k]); x = kx[k];
        ptr_m = (k + 1) % NK;
        if (scramble) begin
            kc[k] = 2'($urandom); ks[k] = 2'($urandom); kx[k] = 1'($urandom);
            if ($urandom_range(0, 3) == 0) reqv[k] = 1'b0;
            apply();
        end
        fc = x || s == 0 || s > c;
        if (c == 0) begin
            L = 0; ed = 0; er = 0; ee = 1;
        end else if (silent_exp) begin
            L = c + 2 + TO; ed = 0; er = 0; ee = 1;
        end else begin
            L  = c + 3;
            ed = fc ? 0 : s;
            er = fc ? c : c - s;
            ee = (!x && (s == 0 || s > c)) ? 1 : 0;
        end
        n = 0; coins_seen = 0; cmd_seen = 0; sel_seen = 0; canc_seen = 0;
        while (kif.done == '0 && n < 60) begin
            coins_seen += int'(core_coin_in);
            canc_seen  += int'(core_cancel);
            if (core_cancel || core_selection != '0) cmd_seen++;
            if (core_selection != '0) sel_seen = int'(core_selection);
            @(negedge clk);
            n++;
        end
        check("latency", n, L);
        check("done", 32'(kif.done), 32'(1 << k));
        check("gnt_at_done", 32'(kif.gnt), 32'(1 << k));
        check("drink", 32'(kif.rsp_drink), ed);
        check("refund", 32'(kif.rsp_refund), er);
        check("err", 32'(kif.err), ee);
        check("coin_strobes", coins_seen, c);
        check("cmd_cycles", cmd_seen, (c == 0) ? 0 : 1);
        check("cmd_sel", sel_seen, (c == 0 || fc) ? 0 : s);
        check("cmd_cancel", canc_seen, (c != 0 && fc) ? 1 : 0);
        if (drop_mode == 1) reqv[k] = 1'b0;
        else if (drop_mode == 2) reqv = '0;
        apply();
        @(negedge clk);
        if (!reqv[k]) begin
            check("done_pulse", 32'(kif.done[k]), 0);
            check("gnt_drop", 32'(kif.gnt[k]), 0);
        end
    endtask

    initial begin
        reqv = '0;
        for (int i = 0; i < NK; i++) begin kc[i] = '0; ks[i] = '0; kx[i] = 1'b0; end
        apply();
        silent = 1'b0; cs_load = 1'b0; cs_load_val = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(kif.gnt), 0);
        check("rst_done", 32'(kif.done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_coin", 32'(core_coin_in), 0);
        check("rst_cancel", 32'(core_cancel), 0);
        check("rst_sel", 32'(core_selection), 0);
        check("rst_rsp", {28'd0, kif.rsp_drink, kif.rsp_refund}, 0);
        check("rst_err", 32'(kif.err), 0);
        rst = 1'b0;
        @(negedge clk);

        set_kiosk(0, 2, 2, 0); serve(1, 0, 0);
        set_kiosk(1, 3, 1, 0); serve(1, 0, 0);
        set_kiosk(1, 3, 2, 1); serve(1, 0, 0);
        set_kiosk(0, 1, 3, 0); serve(1, 0, 0);
        set_kiosk(0, 0, 1, 0); serve(1, 0, 0);

        set_kiosk(0, 1, 1, 0); set_kiosk(1, 1, 1, 0);
        serve(0, 0, 0); serve(0, 0, 0); serve(0, 0, 0); serve(2, 0, 0);

        silent = 1'b1;
        set_kiosk(0, 2, 1, 0); serve(1, 0, 1);
        silent = 1'b0;

        cs_load_val = 2'd2; cs_load = 1'b1;
        @(negedge clk);
        cs_load = 1'b0;
        set_kiosk(1, 1, 1, 0);
        @(negedge clk);
        check("flush_cancel", 32'(core_cancel), 1);
        check("flush_gnt", 32'(kif.gnt), 0);
        check("flush_busy", 32'(busy), 1);
        @(negedge clk);
        check("flush_no_done", 32'(kif.done), 0);
        serve(1, 0, 0);

        set_kiosk(0, 3, 1, 0);
        begin
            int n = 0;
            while (kif.gnt == '0 && n < 50) begin @(negedge clk); n++; end
        end
        check("abort_grant", 32'(kif.gnt), 1);
        rst = 1'b1; reqv = '0; apply();
        @(negedge clk);
        check("abort_gnt", 32'(kif.gnt), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_core", {29'd0, core_coin_in, core_cancel, |core_selection}, 0);
        check("abort_done", 32'(kif.done), 0);
        rst = 1'b0; ptr_m = 0;
        @(negedge clk);
        set_kiosk(0, 1, 1, 0); set_kiosk(1, 2, 1, 0);
        serve(1, 0, 0); serve(1, 0, 0);

        repeat (40) begin
            reqv = '0;
            while (reqv == '0) reqv = NK'($urandom);
            for (int i = 0; i < NK; i++) begin
                kc[i] = 2'($urandom); ks[i] = 2'($urandom); kx[i] = ($urandom_range(0, 4) == 0);
            end
            apply();
            while (reqv != '0) serve(1, 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vend_kiosk_arbiter.md
Name: vend_kiosk_arbiter

Overview:
Shares one vending core between NUM_KIOSK customer kiosks. Each kiosk presents a complete transaction: coin count, drink selection and cancel flag. A round-robin arbiter grants one kiosk at a time, replays the transaction to the core as single-cycle coin/selection/cancel strobes, and returns the core's drink/refund result to the granted kiosk. The block sits between the kiosk front-panel logic and the vending core, and is the only driver of the core's inputs.

Parameters:
NUM_KIOSK, 2, number of requesting kiosks (2..8)
TIMEOUT, 15, max cycles in RESP waiting for a nonzero core result

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high; shared with the vending core
req  in  NUM_KIOSK  per-kiosk transaction request; level, held until done
req_coins  in  2*NUM_KIOSK  per-kiosk coin count 0..3 (kiosk i at [2i+1:2i])
req_sel  in  2*NUM_KIOSK  per-kiosk selection: 00 none, 01 water, 10 coke, 11 coffee
req_cancel  in  NUM_KIOSK  per-kiosk cancel flag
gnt  out  NUM_KIOSK  one-hot grant; high from grant through the done cycle
done  out  NUM_KIOSK  one-cycle completion pulse to the granted kiosk
rsp_drink  out  2  drink dispensed; valid while any done bit is high
rsp_refund  out  2  coins refunded; valid while any done bit is high
err  out  1  one-cycle pulse with done when the result is an error
busy  out  1  high whenever state != IDLE
core_coin_in  out  1  coin strobe to the core
core_cancel  out  1  cancel strobe to the core
core_selection  out  2  selection to the core
core_drink_out  in  2  core drink result; registered, one cycle wide
core_refund  in  2  core refund result; registered, one cycle wide
core_state  in  2  core coin count, 0..3

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the round-robin pointer is 0. Reset mid-transaction aborts without a done pulse; the core is reset by the same rst.
- Core contract: every input is sampled at posedge. A coin increments core_state. A selection or cancel with no coin produces a one-cycle drink/refund result on the next cycle and returns core_state to 0. Prices: water 1, coke 2, coffee 3. Change = coins - price. An unaffordable selection is ignored by the core.
- core_* outputs are Moore-decoded from the state register and are 0 in every state other than COIN, CMD and FLUSH.
- States and transitions:
  - IDLE: if core_state != 0, go to FLUSH. Otherwise, if any req bit is set, grant the first requester at or after the pointer (wrapping) and latch its coins, sel and cancel. Set the pointer to the granted index + 1 (mod NUM_KIOSK). Next state is COIN, or REJECT if coins == 0.
  - COIN: core_coin_in = 1 for exactly coins cycles, then CHECK.
  - CHECK (1 cycle): if core_state != latched coins, mark err and force the command to cancel. Then go to CMD.
  - CMD (1 cycle): drive the command for one cycle, then go to RESP.
    - Command is cancel if cancel is set, sel == 00, or price > coins; err is marked for the last two cases.
    - Cancel takes priority over selection.
    - For a cancel, drive core_cancel = 1 and core_selection = 00. Otherwise drive core_selection = sel.
  - RESP: capture core_drink_out/core_refund on the first cycle either is nonzero, then pulse done[g] and go to IDLE.
    - Result arriving in the first RESP cycle is the nominal case.
    - If TIMEOUT cycles pass with no result, pulse done[g] with zero rsp, err = 1, and go to IDLE.
  - REJECT (1 cycle): done[g] = 1, rsp = 0, err = 1, no core activity.
  - FLUSH: core_cancel = 1 for one cycle. Any refund is discarded. Return to IDLE.
- Nominal latency: done is high in the cycle after edge coins+3, counted from the grant edge.
- Handshake rules:
  - gnt drops in the cycle after done.
  - A kiosk that still holds req after done is re-arbitrated behind the other requesters.
  - req fields are ignored after latching.
  - Deasserting req mid-transaction does not abort the transaction.
- Simultaneous requests: exactly one grant per IDLE decision. Losers hold their req.
- Widths: coins and price compare unsigned on 2 bits. The TIMEOUT counter is $clog2(TIMEOUT+1) bits wide and saturates.

Test Plan:
1. Kiosk0 coins=2, sel=10 → core_coin_in high 2 cycles, then core_selection=10 for 1 cycle; done[0] with rsp_drink=10, rsp_refund=00, err=0, 5 edges after grant.
2. Kiosk1 coins=3, sel=01 → rsp_drink=01, rsp_refund=10. Then coins=3, cancel=1 → rsp_drink=00, rsp_refund=11.
3. Kiosk0 coins=1, sel=11 → command forced to cancel; rsp_refund=01, err=1. Then coins=0 → REJECT: done in the cycle after grant, rsp=0, err=1, no coin strobes.
4. req=11 held continuously with coins=1, sel=01 → grants alternate 0,1,0,1 and every done carries rsp_drink=01.
5. Core model that never responds → done after TIMEOUT=15 RESP cycles with rsp=0, err=1. Core holding core_state=10 at IDLE → one FLUSH cycle with core_cancel=1 before any grant.
6. rst asserted during COIN → next cycle gnt=0, busy=0, core_*=0, no done pulse; pointer resets to 0.
